// File: rtl/move_sched_pkg.sv
// Shared types and helpers for the move scheduler: direction codes, FSM
// state encoding and the one-hot direction decoder.
package move_sched_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_COOL  = 3'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } dir_req_t;

  // Bit order of the vector is {right,left,down,up}; anything other than
  // exactly one set bit decodes as not valid.
  function automatic dir_req_t onehot_to_dir(input logic [3:0] vec);
    dir_req_t r;
    r.valid = 1'b1;
    r.dir   = DIR_UP;
    case (vec)
      4'b0001: r.dir = DIR_UP;
      4'b0010: r.dir = DIR_DOWN;
      4'b0100: r.dir = DIR_LEFT;
      4'b1000: r.dir = DIR_RIGHT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_scheduler_req_edge_detect.sv
// Rising-edge detector for a 4-bit direction level input; reports a single
// decoded direction or flags the edge set as ambiguous.
module req_edge_detect
  import move_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [3:0] level_i,
  output logic       req_valid_o,
  output logic [1:0] req_dir_o,
  output logic       amb_o
);

  logic [3:0] level_q;
  logic [3:0] rise;
  dir_req_t   dec;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_i;
  end

  assign rise        = en_i ? (level_i & ~level_q) : 4'b0000;
  assign dec         = onehot_to_dir(rise);
  assign req_valid_o = dec.valid;
  assign req_dir_o   = dec.dir;
  assign amb_o       = (|rise) & ~dec.valid;

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates move requests from buttons, gamepad and debug into a one-entry
// pending slot and issues them to the game logic on a valid/ready handshake.
module move_scheduler
  import move_sched_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 2,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int DROP_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            btn_dir,
  input  logic [3:0]            pad_dir,
  input  logic                  pad_start,
  input  logic [3:0]            dbg_dir,
  input  logic                  frame_tick,
  input  logic                  welcome_active,
  input  logic                  move_ready,
  input  logic                  move_done,
  output logic                  move_valid,
  output logic [1:0]            move_dir,
  output logic                  move_dbg,
  output logic                  exit_welcome,
  output logic [DROP_CNT_W-1:0] dropped_cnt,
  output logic                  timeout_err,
  output logic [2:0]            state_dbg
);

  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int COOL_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LAST =
    COOL_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);

  state_e                state_q, state_d;
  logic                  armed_q;
  logic                  start_q;
  logic                  slot_full_q, slot_full_d;
  logic [1:0]            slot_dir_q, slot_dir_d;
  logic                  slot_dbg_q, slot_dbg_d;
  logic                  busy_dbg_q, busy_dbg_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [COOL_W-1:0]     cool_cnt_q, cool_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  exit_q, exit_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;

  logic       btn_valid, btn_amb, pad_valid, pad_amb;
  logic [1:0] btn_dir_dec, pad_dir_dec;
  dir_req_t   dbg_req;
  logic       dbg_amb, start_rise, btn_req, pad_req;
  logic       win_valid, win_dbg, blocked, accept, replace_ok;
  logic [1:0] win_dir, losers, drop_events, drop_inc;
  logic [DROP_CNT_W:0] drop_sum;

  // armed_q masks edges on the first cycle out of reset, so levels already
  // high during reset are absorbed into the edge registers silently.
  req_edge_detect u_btn_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (armed_q),
    .level_i    (btn_dir),
    .req_valid_o(btn_valid),
    .req_dir_o  (btn_dir_dec),
    .amb_o      (btn_amb)
  );

  req_edge_detect u_pad_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (armed_q),
    .level_i    (pad_dir),
    .req_valid_o(pad_valid),
    .req_dir_o  (pad_dir_dec),
    .amb_o      (pad_amb)
  );

  assign dbg_req    = onehot_to_dir(dbg_dir);
  assign dbg_amb    = (|dbg_dir) & ~dbg_req.valid;
  assign start_rise = armed_q & pad_start & ~start_q;

  // The welcome screen turns player input into an exit request instead of a move.
  assign btn_req = btn_valid & ~welcome_active;
  assign pad_req = pad_valid & ~welcome_active;
  assign exit_d  = welcome_active & (btn_valid | pad_valid | start_rise);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_dir   = DIR_UP;
    win_dbg   = 1'b0;
    losers    = 2'd0;
    if (dbg_req.valid) begin
      win_valid = 1'b1;
      win_dir   = dbg_req.dir;
      win_dbg   = 1'b1;
      losers    = 2'(pad_req) + 2'(btn_req);
    end else if (pad_req) begin
      win_valid = 1'b1;
      win_dir   = pad_dir_dec;
      losers    = 2'(btn_req);
    end else if (btn_req) begin
      win_valid = 1'b1;
      win_dir   = btn_dir_dec;
    end
  end

  assign accept     = (state_q == ST_ISSUE) & move_ready;
  // The entry on offer in ISSUE is locked so move_dir stays stable while valid.
  assign replace_ok = win_dbg & slot_full_q & ~slot_dbg_q & (state_q != ST_ISSUE);

  always_comb begin
    slot_full_d = slot_full_q;
    slot_dir_d  = slot_dir_q;
    slot_dbg_d  = slot_dbg_q;
    blocked     = 1'b0;
    if (accept) begin
      slot_full_d = 1'b0;
      slot_dir_d  = DIR_UP;
      slot_dbg_d  = 1'b0;
    end
    if (win_valid) begin
      if (!slot_full_q || accept || replace_ok) begin
        slot_full_d = 1'b1;
        slot_dir_d  = win_dir;
        slot_dbg_d  = win_dbg;
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // Each source contributes at most one drop event, so the sum never exceeds 3.
  always_comb begin
    drop_events = 2'(btn_amb) + 2'(pad_amb) + 2'(dbg_amb) + losers + 2'(blocked);
    drop_inc    = (drop_events == 2'd3) ? 2'd2 : drop_events;
    drop_sum    = {1'b0, dropped_q} + (DROP_CNT_W + 1)'(drop_inc);
    dropped_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    cool_cnt_d = cool_cnt_q;
    busy_dbg_d = busy_dbg_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (slot_full_q && (slot_dbg_q || frame_tick)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (move_ready) begin
          state_d    = ST_BUSY;
          tmo_cnt_d  = '0;
          busy_dbg_d = slot_dbg_q;
        end
      end
      ST_BUSY: begin
        if (move_done) begin
          if ((COOLDOWN_FRAMES > 0) && !busy_dbg_q) begin
            state_d    = ST_COOL;
            cool_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_COOL: begin
        if (frame_tick) begin
          if (cool_cnt_q == COOL_LAST) state_d = ST_IDLE;
          else                         cool_cnt_d = cool_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      start_q     <= 1'b0;
      slot_full_q <= 1'b0;
      slot_dir_q  <= DIR_UP;
      slot_dbg_q  <= 1'b0;
      busy_dbg_q  <= 1'b0;
      tmo_cnt_q   <= '0;
      cool_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      exit_q      <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      start_q     <= pad_start;
      slot_full_q <= slot_full_d;
      slot_dir_q  <= slot_dir_d;
      slot_dbg_q  <= slot_dbg_d;
      busy_dbg_q  <= busy_dbg_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      timeout_q   <= timeout_d;
      exit_q      <= exit_d;
      dropped_q   <= dropped_d;
    end
  end

  assign move_valid   = (state_q == ST_ISSUE);
  assign move_dir     = slot_dir_q;
  assign move_dbg     = slot_dbg_q;
  assign exit_welcome = exit_q;
  assign dropped_cnt  = dropped_q;
  assign timeout_err  = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed scenarios plus a randomized run compared cycle by cycle against a
// behavioural model of the scheduler's rules.
module tb_move_scheduler;

  localparam int COOL = 2;
  localparam int TMO  = 1024;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    btn_dir, pad_dir, dbg_dir;
  logic          pad_start, frame_tick, welcome_active, move_ready, move_done;
  logic          move_valid, move_dbg, exit_welcome, timeout_err;
  logic [1:0]    move_dir;
  logic [DW-1:0] dropped_cnt;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  move_scheduler #(
    .COOLDOWN_FRAMES(COOL),
    .TIMEOUT_CYCLES (TMO),
    .DROP_CNT_W     (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_dir       (btn_dir),
    .pad_dir       (pad_dir),
    .pad_start     (pad_start),
    .dbg_dir       (dbg_dir),
    .frame_tick    (frame_tick),
    .welcome_active(welcome_active),
    .move_ready    (move_ready),
    .move_done     (move_done),
    .move_valid    (move_valid),
    .move_dir      (move_dir),
    .move_dbg      (move_dbg),
    .exit_welcome  (exit_welcome),
    .dropped_cnt   (dropped_cnt),
    .timeout_err   (timeout_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- behavioural model ----------------
  typedef struct { int dir; bit dbg; } req_t;

  bit [3:0] m_prev_btn, m_prev_pad;
  bit       m_prev_start, m_armed;
  bit       m_slot_full, m_slot_dbg, m_busy_dbg, m_timeout, m_exit;
  int       m_slot_dir, m_phase, m_busy_cycles, m_cool_ticks, m_drops;

  function automatic int dir_of(input bit [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_update();
    bit [3:0] br, pr;
    bit       sr, accept;
    int       bd, pd, dd, events, old_phase;
    req_t     q[$];
    if (!rst_n) begin
      m_prev_btn = 0; m_prev_pad = 0; m_prev_start = 0; m_armed = 0;
      m_slot_full = 0; m_slot_dbg = 0; m_slot_dir = 0; m_busy_dbg = 0;
      m_timeout = 0; m_exit = 0; m_phase = 0; m_busy_cycles = 0;
      m_cool_ticks = 0; m_drops = 0;
      return;
    end
    br = m_armed ? (btn_dir & ~m_prev_btn) : 4'b0;
    pr = m_armed ? (pad_dir & ~m_prev_pad) : 4'b0;
    sr = m_armed && pad_start && !m_prev_start;
    bd = dir_of(br); pd = dir_of(pr); dd = dir_of(dbg_dir);
    events = 0;
    if (br != 0 && bd < 0) events++;
    if (pr != 0 && pd < 0) events++;
    if (dbg_dir != 0 && dd < 0) events++;
    m_exit = welcome_active && (bd >= 0 || pd >= 0 || sr);
    if (dd >= 0) q.push_back('{dd, 1'b1});
    if (!welcome_active && pd >= 0) q.push_back('{pd, 1'b0});
    if (!welcome_active && bd >= 0) q.push_back('{bd, 1'b0});

    old_phase = m_phase;
    accept = (old_phase == 1) && move_ready;
    case (old_phase)
      0: if (m_slot_full && (m_slot_dbg || frame_tick)) m_phase = 1;
      1: if (move_ready) begin m_phase = 2; m_busy_dbg = m_slot_dbg; m_busy_cycles = 0; end
      2: begin
        m_busy_cycles++;
        if (move_done) begin
          m_phase = (COOL > 0 && !m_busy_dbg) ? 3 : 0;
          m_cool_ticks = 0;
        end else if (m_busy_cycles == TMO) begin
          m_phase = 0; m_timeout = 1;
        end
      end
      3: if (frame_tick) begin
        m_cool_ticks++;
        if (m_cool_ticks == COOL) m_phase = 0;
      end
      default: m_phase = 0;
    endcase

    if (q.size() > 0) begin
      events += q.size() - 1;
      if (!m_slot_full || accept || (q[0].dbg && !m_slot_dbg && old_phase != 1)) begin
        m_slot_full = 1; m_slot_dir = q[0].dir; m_slot_dbg = q[0].dbg;
      end else begin
        events++;
      end
    end else if (accept) begin
      m_slot_full = 0; m_slot_dbg = 0; m_slot_dir = 0;
    end
    m_drops += (events > 2) ? 2 : events;
    if (m_drops > (1 << DW) - 1) m_drops = (1 << DW) - 1;
    m_prev_btn = btn_dir; m_prev_pad = pad_dir; m_prev_start = pad_start; m_armed = 1;
  endtask

  // Advance one clock; outputs are sampled 1 unit after the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    btn_dir = 4'b0001; rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", move_valid); end
    checks++; if (move_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", move_dir); end
    checks++; if (move_dbg !== 1'b0) begin errors++; $display("FAIL reset_dbg: got %0b expected 0", move_dbg); end
    checks++; if (exit_welcome !== 1'b0) begin errors++; $display("FAIL reset_exit: got %0b expected 0", exit_welcome); end
    checks++; if (dropped_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", dropped_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %0b expected 0", timeout_err); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_tick = (i % 2 == 1);
      tick();
      checks++; if (move_valid !== 1'b0 || state_dbg !== 3'd0) begin
        errors++; $display("FAIL held_btn_after_reset: valid=%0b state=%0d expected 0/0", move_valid, state_dbg);
      end
    end
    frame_tick = 1'b0; btn_dir = 4'b0000; tick();
  endtask

  task automatic test_button_move();
    btn_dir = 4'b0100; tick();
    checks++; if (state_dbg !== 3'd0 || move_valid !== 1'b0) begin
      errors++; $display("FAIL btn_wait_tick: state=%0d valid=%0b expected 0/0", state_dbg, move_valid);
    end
    frame_tick = 1'b1; move_ready = 1'b1; tick(); frame_tick = 1'b0;
    checks++; if (move_valid !== 1'b1 || state_dbg !== 3'd1) begin
      errors++; $display("FAIL btn_issue: valid=%0b state=%0d expected 1/1", move_valid, state_dbg);
    end
    checks++; if (move_dir !== 2'd2 || move_dbg !== 1'b0) begin
      errors++; $display("FAIL btn_issue_dir: dir=%0d dbg=%0b expected 2/0", move_dir, move_dbg);
    end
    tick();
    checks++; if (move_valid !== 1'b0 || state_dbg !== 3'd2) begin
      errors++; $display("FAIL btn_busy: valid=%0b state=%0d expected 0/2", move_valid, state_dbg);
    end
    btn_dir = 4'b0000; move_ready = 1'b0; move_done = 1'b1; tick(); move_done = 1'b0;
    checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL btn_cool: state=%0d expected 3", state_dbg); end
    frames(2);
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL btn_back_idle: state=%0d expected 0", state_dbg); end
  endtask

  task automatic test_dbg_priority();
    btn_dir = 4'b0001; dbg_dir = 4'b1000; tick(); dbg_dir = 4'b0000;
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL dbg_lat1: valid=%0b expected 0", move_valid); end
    tick();
    checks++; if (move_valid !== 1'b1) begin errors++; $display("FAIL dbg_lat2: valid=%0b expected 1", move_valid); end
    checks++; if (move_dir !== 2'd3 || move_dbg !== 1'b1) begin
      errors++; $display("FAIL dbg_dir: dir=%0d dbg=%0b expected 3/1", move_dir, move_dbg);
    end
    checks++; if (dropped_cnt !== 8'd1) begin errors++; $display("FAIL dbg_drop: got %0d expected 1", dropped_cnt); end
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    move_done = 1'b1; tick(); move_done = 1'b0;
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL dbg_no_cool: state=%0d expected 0", state_dbg); end
    btn_dir = 4'b0000; tick();
  endtask

  task automatic test_welcome();
    welcome_active = 1'b1; pad_start = 1'b1; tick();
    checks++; if (exit_welcome !== 1'b1) begin errors++; $display("FAIL exit_pulse: got %0b expected 1", exit_welcome); end
    tick();
    checks++; if (exit_welcome !== 1'b0) begin errors++; $display("FAIL exit_width: got %0b expected 0", exit_welcome); end
    for (int f = 0; f < 3; f++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
      checks++; if (move_valid !== 1'b0 || state_dbg !== 3'd0) begin
        errors++; $display("FAIL welcome_gate: valid=%0b state=%0d expected 0/0", move_valid, state_dbg);
      end
    end
    pad_start = 1'b0; welcome_active = 1'b0; tick();
  endtask

  task automatic test_cooldown();
    btn_dir = 4'b1000; tick();
    frame_tick = 1'b1; move_ready = 1'b1; tick(); frame_tick = 1'b0;
    tick();
    move_ready = 1'b0; btn_dir = 4'b0000; move_done = 1'b1; tick(); move_done = 1'b0;
    btn_dir = 4'b0010; tick(); btn_dir = 4'b0000;
    checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL cool_enter: state=%0d expected 3", state_dbg); end
    frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL cool_tick1: state=%0d expected 3", state_dbg); end
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    checks++; if (state_dbg !== 3'd0 || move_valid !== 1'b0) begin
      errors++; $display("FAIL cool_exit: state=%0d valid=%0b expected 0/0", state_dbg, move_valid);
    end
    repeat (3) tick();
    checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL cool_wait_frame: valid=%0b expected 0", move_valid); end
    frame_tick = 1'b1; move_ready = 1'b1; tick(); frame_tick = 1'b0;
    checks++; if (move_valid !== 1'b1 || move_dir !== 2'd1) begin
      errors++; $display("FAIL cool_reissue: valid=%0b dir=%0d expected 1/1", move_valid, move_dir);
    end
    tick(); move_ready = 1'b0; move_done = 1'b1; tick(); move_done = 1'b0;
    frames(2);
  endtask

  task automatic test_timeout();
    int n;
    btn_dir = 4'b0001; tick(); btn_dir = 4'b0000;
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin
        errors++; $display("FAIL stall_stable: valid=%0b dir=%0d expected 1/0", move_valid, move_dir);
      end
      tick();
    end
    move_ready = 1'b1; tick(); move_ready = 1'b0;
    checks++; if (state_dbg !== 3'd2 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL tmo_enter: state=%0d tmo=%0b expected 2/0", state_dbg, timeout_err);
    end
    n = 0;
    while (state_dbg == 3'd2 && n < 1100) begin tick(); n++; end
    checks++; if (n != TMO) begin errors++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TMO); end
    checks++; if (timeout_err !== 1'b1 || state_dbg !== 3'd0) begin
      errors++; $display("FAIL tmo_flag: tmo=%0b state=%0d expected 1/0", timeout_err, state_dbg);
    end
  endtask

  task automatic test_saturate();
    btn_dir = 4'b0100; tick(); btn_dir = 4'b0000; tick();
    btn_dir = 4'b0011; tick(); btn_dir = 4'b0000; tick();
    checks++; if (dropped_cnt !== 8'd2) begin errors++; $display("FAIL amb_one_drop: got %0d expected 2", dropped_cnt); end
    for (int i = 0; i < 300; i++) begin
      btn_dir = 4'b0001; tick(); btn_dir = 4'b0000; tick();
    end
    checks++; if (dropped_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", dropped_cnt); end
    frame_tick = 1'b1; move_ready = 1'b1; tick(); frame_tick = 1'b0;
    checks++; if (move_valid !== 1'b1 || move_dir !== 2'd2) begin
      errors++; $display("FAIL slot_kept: valid=%0b dir=%0d expected 1/2", move_valid, move_dir);
    end
    tick(); move_ready = 1'b0; move_done = 1'b1; tick(); move_done = 1'b0;
    frames(2);
  endtask

  task automatic test_random();
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    for (int c = 0; c < 5000 && errors < 30; c++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 5) == 0)
        btn_dir = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        pad_dir = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pad_start = ~pad_start;
      if ($urandom_range(0, 149) == 0) welcome_active = ~welcome_active;
      dbg_dir = 4'b0000;
      if ($urandom_range(0, 24) == 0)
        dbg_dir = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      frame_tick = ($urandom_range(0, 7) == 0);
      move_ready = 1'($urandom_range(0, 1));
      move_done  = ($urandom_range(0, 11) == 0);
      tick();
      checks++; if (move_valid !== (m_phase == 1)) begin
        errors++; $display("FAIL rnd_valid cyc %0d: got %0b expected %0b", c, move_valid, m_phase == 1);
      end
      checks++; if (state_dbg !== 3'(m_phase)) begin
        errors++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", c, state_dbg, m_phase);
      end
      checks++; if (dropped_cnt !== DW'(m_drops)) begin
        errors++; $display("FAIL rnd_drop cyc %0d: got %0d expected %0d", c, dropped_cnt, m_drops);
      end
      checks++; if (timeout_err !== m_timeout || exit_welcome !== m_exit) begin
        errors++; $display("FAIL rnd_flags cyc %0d: tmo=%0b exit=%0b expected %0b/%0b", c, timeout_err, exit_welcome, m_timeout, m_exit);
      end
      if (m_phase == 1) begin
        checks++; if (move_dir !== 2'(m_slot_dir) || move_dbg !== m_slot_dbg) begin
          errors++; $display("FAIL rnd_move cyc %0d: dir=%0d dbg=%0b expected %0d/%0b", c, move_dir, move_dbg, m_slot_dir, m_slot_dbg);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; btn_dir = 4'b0; pad_dir = 4'b0; dbg_dir = 4'b0;
    pad_start = 1'b0; frame_tick = 1'b0; welcome_active = 1'b0;
    move_ready = 1'b0; move_done = 1'b0;
    test_reset();
    test_button_move();
    test_dbg_priority();
    test_welcome();
    test_cooldown();
    test_timeout();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
